// File: rtl/imem_loader.sv
// imem_loader: byte-serial writer for the core's 16-entry instruction RAM.
// Takes a length-prefixed stream of little-endian 32-bit words over a
// valid/ready byte handshake, fills the RAM and releases the core via
// core_run once the load completes. The RAM is read combinationally at pc.
//
// Optional feature: define IMEM_CHECKSUM_EN to require a trailing XOR
// checksum byte (count byte ^ all payload bytes) before entering RUN.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   byte_in     load stream byte
//   byte_valid  byte_in valid
//   byte_ready  loader accepts a byte this cycle
//   load_start  single-cycle request to begin/restart a load
//   pc          core fetch address
//   instr       instruction at pc, 0 when the entry is not loaded
//   core_run    core may advance pc and write back
//   load_done   one-cycle pulse on successful load
//   err         load failed; sticky until load_start or reset
module imem_loader #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic              core_run,
    output logic              load_done,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD_CNT  = 3'd1;
    localparam logic [2:0] S_LOAD_DATA = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_ERR       = 3'd4;
`ifdef IMEM_CHECKSUM_EN
    localparam logic [2:0] S_LOAD_SUM  = 3'd5;
`endif

    logic [2:0]        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  nwords_q, nwords_d;
    logic [23:0]       wbuf_q, wbuf_d;
`ifdef IMEM_CHECKSUM_EN
    logic [7:0]        acc_q, acc_d;
`endif

    logic              byte_ready_q, core_run_q, load_done_q, err_q;
    logic              loading_d;

    logic              accept_c;
    logic              we_c;
    logic [31:0]       wdata_c;
    logic              valid_clr_c;

    logic [DEPTH-1:0]  valid_q;
    logic [31:0]       ram [DEPTH];

    // load_start has priority: a byte offered in the same cycle is dropped
    assign accept_c = byte_valid && byte_ready_q && !load_start;

    // Next-state, datapath and RAM write control
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        nwords_d    = nwords_q;
        wbuf_d      = wbuf_q;
`ifdef IMEM_CHECKSUM_EN
        acc_d       = acc_q;
`endif
        we_c        = 1'b0;
        wdata_c     = 32'h0;
        valid_clr_c = 1'b0;
        loading_d   = 1'b0;

        if (load_start) begin
            state_d     = S_LOAD_CNT;
            idx_d       = 2'd0;
            addr_d      = '0;
            nwords_d    = '0;
`ifdef IMEM_CHECKSUM_EN
            acc_d       = 8'h0;
`endif
            valid_clr_c = 1'b1;
        end else begin
            case (state_q)
                S_LOAD_CNT: begin
                    if (accept_c) begin
                        if (byte_in > 8'(DEPTH)) begin
                            state_d = S_ERR;
                        end else begin
                            // count 0 encodes a full RAM
                            nwords_d = (byte_in == 8'h0) ? CNT_W'(DEPTH) : CNT_W'(byte_in);
`ifdef IMEM_CHECKSUM_EN
                            acc_d    = byte_in;
`endif
                            state_d  = S_LOAD_DATA;
                        end
                    end
                end
                S_LOAD_DATA: begin
                    if (accept_c) begin
`ifdef IMEM_CHECKSUM_EN
                        acc_d = acc_q ^ byte_in;
`endif
                        if (idx_q == 2'd3) begin
                            we_c    = 1'b1;
                            wdata_c = {byte_in, wbuf_q};
                            addr_d  = addr_q + ADDR_W'(1);
                            idx_d   = 2'd0;
                            if ((CNT_W'(addr_q) + CNT_W'(1)) == nwords_q) begin
`ifdef IMEM_CHECKSUM_EN
                                state_d = S_LOAD_SUM;
`else
                                state_d = S_RUN;
`endif
                            end
                        end else begin
                            // little-endian: first byte lands in bits [7:0]
                            case (idx_q)
                                2'd0:    wbuf_d[7:0]   = byte_in;
                                2'd1:    wbuf_d[15:8]  = byte_in;
                                default: wbuf_d[23:16] = byte_in;
                            endcase
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end
`ifdef IMEM_CHECKSUM_EN
                S_LOAD_SUM: begin
                    if (accept_c) begin
                        state_d = (byte_in == acc_q) ? S_RUN : S_ERR;
                    end
                end
`endif
                default: begin
                end
            endcase
        end

        loading_d = (state_d == S_LOAD_CNT) || (state_d == S_LOAD_DATA);
`ifdef IMEM_CHECKSUM_EN
        loading_d = loading_d || (state_d == S_LOAD_SUM);
`endif
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            addr_q       <= '0;
            nwords_q     <= '0;
            wbuf_q       <= 24'h0;
`ifdef IMEM_CHECKSUM_EN
            acc_q        <= 8'h0;
`endif
            byte_ready_q <= 1'b0;
            core_run_q   <= 1'b0;
            load_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            nwords_q     <= nwords_d;
            wbuf_q       <= wbuf_d;
`ifdef IMEM_CHECKSUM_EN
            acc_q        <= acc_d;
`endif
            byte_ready_q <= loading_d;
            core_run_q   <= (state_d == S_RUN);
            load_done_q  <= (state_d == S_RUN) && (state_q != S_RUN);
            err_q        <= (state_d == S_ERR);
        end
    end

    // Per-entry valid bits gate every read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (valid_clr_c) begin
            valid_q <= '0;
        end else if (we_c) begin
            valid_q[addr_q] <= 1'b1;
        end
    end

    // Instruction storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (we_c) begin
            ram[addr_q] <= wdata_c;
        end
    end

    assign instr      = valid_q[pc] ? ram[pc] : 32'h0;
    assign byte_ready = byte_ready_q;
    assign core_run   = core_run_q;
    assign load_done  = load_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed test-plan sequences, a
// table of expected RAM readback, and randomized loads checked against a
// stream-level reference model.
module tb_imem_loader;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [3:0]  pc;
        logic [31:0] exp_instr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        load_start;
    logic [3:0]  pc;
    logic [31:0] instr;
    logic        core_run;
    logic        load_done;
    logic        err;

    int checks = 0;
    int errors = 0;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .load_start (load_start),
        .pc         (pc),
        .instr      (instr),
        .core_run   (core_run),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what pc p should read after loading stream s
    function automatic logic [31:0] model_instr(input bq_t s, input int p);
        int n;
        n = int'(s[0]);
        if (n > 16) return 32'h0;
        if (n == 0) n = 16;
        if (p >= n) return 32'h0;
        return {s[4*p+4], s[4*p+3], s[4*p+2], s[4*p+1]};
    endfunction

    // Reference: does stream s complete successfully
    function automatic bit model_ok(input bq_t s);
`ifdef IMEM_CHECKSUM_EN
        logic [7:0] x;
`endif
        if (int'(s[0]) > 16) return 1'b0;
`ifdef IMEM_CHECKSUM_EN
        x = 8'h0;
        for (int i = 0; i < s.size() - 1; i++) x ^= s[i];
        return x == s[s.size()-1];
`else
        return 1'b1;
`endif
    endfunction

    task automatic mk_stream(input logic [7:0] nb, input logic [31:0] w[$], output bq_t s);
        logic [7:0] x;
        s = {};
        s.push_back(nb);
        foreach (w[i]) begin
            s.push_back(w[i][7:0]);
            s.push_back(w[i][15:8]);
            s.push_back(w[i][23:16]);
            s.push_back(w[i][31:24]);
        end
        x = 8'h0;
        foreach (s[i]) x ^= s[i];
`ifdef IMEM_CHECKSUM_EN
        s.push_back(x);
`endif
    endtask

    task automatic pulse_start(input logic v, input logic [7:0] b);
        load_start = 1'b1;
        byte_valid = v;
        byte_in    = b;
        tick();
        load_start = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap_max);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 1)) : 0;
        for (int i = 0; i < g; i++) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            tick();
            check("ready_in_gap", 32'(byte_ready), 32'd1);
        end
        check("ready_before_byte", 32'(byte_ready), 32'd1);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic run_load(input string nm, input bq_t s, input logic start_valid, input int gap_max);
        bit ok;
        pulse_start(start_valid, 8'h05);
        check({nm, "_start_ready"}, 32'(byte_ready), 32'd1);
        check({nm, "_start_run"}, 32'(core_run), 32'd0);
        check({nm, "_start_err"}, 32'(err), 32'd0);
        for (int i = 0; i < s.size(); i++) begin
            send(s[i], gap_max);
            if (i < s.size() - 1) begin
                check({nm, "_early_done"}, 32'(load_done), 32'd0);
                check({nm, "_early_run"}, 32'(core_run), 32'd0);
            end
        end
        ok = model_ok(s);
        check({nm, "_done"}, 32'(load_done), 32'(ok));
        check({nm, "_run"}, 32'(core_run), 32'(ok));
        check({nm, "_err"}, 32'(err), 32'(!ok));
        check({nm, "_ready_after"}, 32'(byte_ready), 32'd0);
        tick();
        check({nm, "_done_once"}, 32'(load_done), 32'd0);
        check({nm, "_run_hold"}, 32'(core_run), 32'(ok));
        for (int p = 0; p < 16; p++) begin
            pc = 4'(p);
            #1;
            check($sformatf("%s_instr%0d", nm, p), instr, model_instr(s, p));
        end
    endtask

    task automatic check_all_zero(input string nm);
        for (int p = 0; p < 16; p++) begin
            pc = 4'(p);
            #1;
            check($sformatf("%s_instr%0d", nm, p), instr, 32'h0);
        end
    endtask

    initial begin
        vec_t        tbl[16];
        bq_t         s;
        logic [31:0] w[$];
        logic [7:0]  nb;
        int          n;

        for (int i = 0; i < 16; i++) tbl[i] = '{pc: 4'(i), exp_instr: 32'h0};
        tbl[0].exp_instr = 32'h003100B3;
        tbl[1].exp_instr = 32'h403100B3;

        rst_n      = 1'b0;
        byte_in    = 8'h0;
        byte_valid = 1'b0;
        load_start = 1'b0;
        pc         = 4'h0;
        #3;
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_run", 32'(core_run), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check_all_zero("rst");
        #4;
        rst_n = 1'b1;
        tick();

        // IDLE ignores the stream
        byte_valid = 1'b1;
        byte_in    = 8'h01;
        tick();
        tick();
        byte_valid = 1'b0;
        check("idle_ready", 32'(byte_ready), 32'd0);
        check("idle_run", 32'(core_run), 32'd0);

        // Test-plan load, then table readback
        w = {32'h003100B3, 32'h403100B3};
        mk_stream(8'h02, w, s);
        run_load("basic", s, 1'b0, 0);
        for (int i = 0; i < 16; i++) begin
            pc = tbl[i].pc;
            #1;
            check($sformatf("tbl_pc%0d", i), instr, tbl[i].exp_instr);
        end

        // Same stream with random byte_valid gaps
        run_load("gaps", s, 1'b0, 5);

        // Oversized count, then recovery
        s = {8'h11};
        run_load("cnt17", s, 1'b0, 0);
        tick();
        check("cnt17_err_sticky", 32'(err), 32'd1);
        check("cnt17_ready_sticky", 32'(byte_ready), 32'd0);
        w = {32'h00000013};
        mk_stream(8'h01, w, s);
        run_load("recover", s, 1'b0, 0);

        // Abort after one full word plus two bytes
        pulse_start(1'b0, 8'h00);
        send(8'h02, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        send(8'h44, 0);
        send(8'h55, 0);
        send(8'h66, 0);
        run_load("abort", s, 1'b0, 0);

        // load_start with byte_valid: the byte must not be taken as count
        run_load("start_wins", s, 1'b1, 0);

        // load_start in RUN drops core_run next cycle
        pulse_start(1'b0, 8'h00);
        check("restart_run_drop", 32'(core_run), 32'd0);

        // Reset in RUN: outputs drop asynchronously
        w = {32'h003100B3, 32'h403100B3};
        mk_stream(8'h02, w, s);
        run_load("pre_rst", s, 1'b0, 0);
        pc = 4'h0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_run", 32'(core_run), 32'd0);
        check("arst_instr", instr, 32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        check_all_zero("run_rst");

        // Reset mid-word: partial bytes must be discarded
        pulse_start(1'b0, 8'h00);
        send(8'h02, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(byte_ready), 32'd0);
        check("mid_rst_run", 32'(core_run), 32'd0);
        check("mid_rst_done", 32'(load_done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check_all_zero("mid_rst");
        w = {32'h00000013};
        mk_stream(8'h01, w, s);
        run_load("post_rst", s, 1'b0, 0);

        // Full RAM (count 0)
        w = {};
        for (int i = 0; i < 16; i++) w.push_back($urandom);
        mk_stream(8'h00, w, s);
        run_load("full", s, 1'b0, 1);

`ifdef IMEM_CHECKSUM_EN
        // Wrong checksum
        w = {32'h003100B3, 32'h403100B3};
        mk_stream(8'h02, w, s);
        s[s.size()-1] = 8'h43;
        run_load("bad_sum", s, 1'b0, 0);
`endif

        // Randomized loads against the model
        for (int it = 0; it < 12; it++) begin
            nb = ($urandom_range(9, 0) == 0) ? 8'($urandom_range(255, 17)) : 8'($urandom_range(16, 0));
            w  = {};
            if (nb <= 8'd16) begin
                n = (nb == 8'd0) ? 16 : int'(nb);
                for (int i = 0; i < n; i++) w.push_back($urandom);
            end
            mk_stream(nb, w, s);
            if (nb > 8'd16) s = {nb};
`ifdef IMEM_CHECKSUM_EN
            if (nb <= 8'd16 && $urandom_range(4, 0) == 0) s[s.size()-1] ^= 8'h01;
`endif
            run_load($sformatf("rnd%0d", it), s, 1'b0, 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
